// File: rtl/mbs_arb_pkg.sv
// Shared types and default constants for the MBS two-core bus arbiter.
// Imported by the round-robin picker and the arbiter top.
package mbs_arb_pkg;

   localparam int DEF_NUM_MST = 2;
   localparam int DEF_TIMEOUT = 16;
   localparam int DEF_TW      = 5;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_e;

endpackage

// File: rtl/mbs_rr_pick.sv
// Combinational round-robin picker: scans masters starting just after the last owner,
// so the last owner only wins when it is the sole requester.
module mbs_rr_pick
   import mbs_arb_pkg::*;
#(
   parameter int NUM_MST = DEF_NUM_MST,
   parameter int IW      = $clog2(NUM_MST)
) (
   input  logic [NUM_MST-1:0] req,
   input  logic [IW-1:0]      last,
   output logic [IW-1:0]      winner,
   output logic               valid
);

   logic [IW-1:0] idx;

   // NOTE: combinational logic uses blocking assignments, with every output defaulted first so no latch is inferred.
   always_comb begin
      winner = last;
      valid  = 1'b0;
      idx    = last;
      for (int k = 1; k <= NUM_MST; k++) begin
         idx = IW'((int'(last) + k) % NUM_MST);
         if (!valid && req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mbs_bus_arbiter.sv
// Shared system bus arbiter for the MBS CPU cores: round-robin grant, lock hold,
// transfer timeout with a one-cycle error pulse, and per-core request masking.
module mbs_bus_arbiter
   import mbs_arb_pkg::*;
#(
   parameter int NUM_MST = DEF_NUM_MST,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int TW      = DEF_TW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_MST-1:0]         cpu_en,
   input  logic [NUM_MST-1:0]         req,
   input  logic [NUM_MST-1:0]         lock,
   input  logic                       done,
   output logic [NUM_MST-1:0]         grant,
   output logic [NUM_MST-1:0]         cpu_pause,
   output logic                       bus_busy,
   output logic [$clog2(NUM_MST)-1:0] owner,
   output logic                       timeout_err
);

   localparam int IW = $clog2(NUM_MST);

   state_e             state;
   logic [TW-1:0]      count;
   logic [NUM_MST-1:0] req_eff;
   logic [NUM_MST-1:0] owner_mask;
   logic [NUM_MST-1:0] pick_req;
   logic [IW-1:0]      pick_idx;
   logic               pick_valid;
   logic               count_max;
   logic               timeout_hit;
   logic               release_bus;

   assign req_eff    = req & cpu_en;
   assign owner_mask = NUM_MST'(1) << owner;

   // While a master owns the bus only the others are candidates for a direct hand-over.
   assign pick_req   = (state == OWN) ? (req_eff & ~owner_mask) : req_eff;

   mbs_rr_pick #(
      .NUM_MST (NUM_MST),
      .IW      (IW)
   ) u_pick (
      .req    (pick_req),
      .last   (owner),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   // A done pulse in the final cycle completes the transfer rather than timing it out.
   assign count_max   = (count == TW'(TIMEOUT - 1));
   assign timeout_hit = count_max && !done && req_eff[owner];
   assign release_bus = (done && !lock[owner]) || !req_eff[owner] || timeout_hit;

   assign cpu_pause = req_eff & ~grant;
   assign bus_busy  = |grant;

   // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous, sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         owner       <= IW'(NUM_MST - 1);
         count       <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state <= OWN;
                  grant <= NUM_MST'(1) << pick_idx;
                  owner <= pick_idx;
                  count <= '0;
               end
            end
            OWN: begin
               if (release_bus) begin
                  count       <= '0;
                  timeout_err <= timeout_hit;
                  if (pick_valid) begin
                     grant <= NUM_MST'(1) << pick_idx;
                     owner <= pick_idx;
                  end else begin
                     state <= IDLE;
                     grant <= '0;
                  end
               end else begin
                  count <= done ? '0 : count + TW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbs_bus_arbiter.sv
// Scoreboard bench for mbs_bus_arbiter: a driver applies inputs on the falling edge and queues
// the reference model's expected outputs; a monitor compares them after each rising edge.
module tb_mbs_bus_arbiter;

   localparam int TIMEOUT = 16;

   typedef struct {
      logic [1:0] grant;
      logic       owner;
      logic       busy;
      logic       terr;
      logic [1:0] pause;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cpu_en = 2'b11;
   logic [1:0] req = 2'b00;
   logic [1:0] lock = 2'b00;
   logic       done = 1'b0;
   logic [1:0] grant;
   logic [1:0] cpu_pause;
   logic       bus_busy;
   logic       owner;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;
   int terr_seen = 0;

   exp_t exp_q[$];

   // Reference model: holder is the granted master or -1, last is the most recent owner.
   int holder = -1;
   int last = 1;
   int held = 0;
   bit m_terr = 1'b0;

   mbs_bus_arbiter #(.NUM_MST(2), .TIMEOUT(TIMEOUT), .TW(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_en      (cpu_en),
      .req         (req),
      .lock        (lock),
      .done        (done),
      .grant       (grant),
      .cpu_pause   (cpu_pause),
      .bus_busy    (bus_busy),
      .owner       (owner),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Applies one cycle of inputs and advances the model to the state after the next rising edge.
   task automatic cyc(input logic r, input logic [1:0] en, input logic [1:0] rq,
                      input logic [1:0] lk, input logic dn);
      logic [1:0] eff;
      exp_t e;
      int o;
      bit timed_out;
      bit rel;
      @(negedge clk);
      rst = r; cpu_en = en; req = rq; lock = lk; done = dn;
      eff = rq & en;
      m_terr = 1'b0;
      if (r) begin
         holder = -1;
         last = 1;
         held = 0;
      end else if (holder < 0) begin
         if (eff == 2'b11) begin
            holder = 1 - last;
            last = holder;
            held = 0;
         end else if (eff != 2'b00) begin
            holder = eff[0] ? 0 : 1;
            last = holder;
            held = 0;
         end
      end else begin
         o = holder;
         timed_out = (held == TIMEOUT - 1) && !dn && eff[o];
         rel = (dn && !lk[o]) || !eff[o] || timed_out;
         m_terr = timed_out;
         if (rel) begin
            held = 0;
            if (eff[1 - o]) begin
               holder = 1 - o;
               last = holder;
            end else begin
               holder = -1;
            end
         end else begin
            held = dn ? 0 : held + 1;
         end
      end
      e.grant = (holder < 0) ? 2'b00 : 2'(1 << holder);
      e.owner = last[0];
      e.busy  = (holder >= 0);
      e.terr  = m_terr;
      e.pause = eff & ~e.grant;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (timeout_err === 1'b1) terr_seen++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant", grant, e.grant);
            check("owner", owner, e.owner);
            check("bus_busy", bus_busy, e.busy);
            check("timeout_err", timeout_err, e.terr);
            check("cpu_pause", cpu_pause, e.pause);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int t0;
      logic [1:0] rq;
      logic [1:0] en;
      logic [1:0] lk;

      // Single requester, then release on done.
      cyc(1, 2'b11, 2'b00, 2'b00, 0);
      repeat (3) cyc(0, 2'b11, 2'b01, 2'b00, 0);
      cyc(0, 2'b11, 2'b01, 2'b00, 1);
      repeat (2) cyc(0, 2'b11, 2'b00, 2'b00, 0);

      // Both request from reset: master 0 first, direct hand-over to master 1.
      cyc(1, 2'b11, 2'b00, 2'b00, 0);
      repeat (3) cyc(0, 2'b11, 2'b11, 2'b00, 0);
      cyc(0, 2'b11, 2'b11, 2'b00, 1);
      repeat (2) cyc(0, 2'b11, 2'b10, 2'b00, 0);
      cyc(0, 2'b11, 2'b10, 2'b00, 1);
      cyc(0, 2'b11, 2'b00, 2'b00, 0);

      // Locked owner survives done pulses, then yields once the lock drops.
      cyc(1, 2'b11, 2'b00, 2'b00, 0);
      repeat (2) cyc(0, 2'b11, 2'b11, 2'b01, 0);
      repeat (3) begin
         cyc(0, 2'b11, 2'b11, 2'b01, 1);
         cyc(0, 2'b11, 2'b11, 2'b01, 0);
      end
      cyc(0, 2'b11, 2'b11, 2'b00, 1);
      repeat (2) cyc(0, 2'b11, 2'b10, 2'b00, 0);

      // Held without done until forced release.
      cyc(1, 2'b11, 2'b00, 2'b00, 0);
      @(posedge clk);
      #2;
      t0 = terr_seen;
      repeat (20) cyc(0, 2'b11, 2'b01, 2'b00, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 0);
      @(posedge clk);
      #2;
      check("timeout_pulse_count", terr_seen - t0, 1);

      // CPU1 disabled, then owner's enable drops mid-transfer.
      cyc(1, 2'b11, 2'b00, 2'b00, 0);
      repeat (4) cyc(0, 2'b01, 2'b11, 2'b00, 0);
      repeat (3) cyc(0, 2'b00, 2'b11, 2'b00, 0);

      // Reset while master 1 owns the bus, then re-arbitration.
      cyc(1, 2'b11, 2'b00, 2'b00, 0);
      repeat (3) cyc(0, 2'b11, 2'b10, 2'b00, 0);
      cyc(1, 2'b11, 2'b10, 2'b00, 0);
      repeat (3) cyc(0, 2'b11, 2'b10, 2'b00, 0);

      // Randomized traffic with frequent completions.
      rq = 2'b00;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(4) == 0) rq = 2'($urandom);
         en = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b11;
         lk = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
         cyc(($urandom_range(99) == 0), en, rq, lk, ($urandom_range(3) == 0));
      end

      // Randomized traffic with rare completions to reach timeouts.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(29) == 0) rq = 2'($urandom);
         lk = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
         cyc(1'b0, 2'b11, rq, lk, ($urandom_range(39) == 0));
      end

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
